sbox_bist: RTL

- On-chip self-test controller that drives a combinational S-box (8-bit byte in, encrypt select, 8-bit byte out) through all 512 vectors: 256 forward, then 256 inverse.
- Compares each result against an internal golden table and reports pass/fail plus the first failing vector.
- Sits beside any S-box variant (depth16 and others) and replaces simulation-only checking with synthesizable checking.

---
 rtl/sbox_bist_pkg.sv | 55 +++++
 rtl/sbox_golden_rom.sv | 16 +
 rtl/sbox_bist.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sbox_bist_pkg.sv
// Shared definitions for the S-box built-in self-test: controller states,
// sweep sizing and the forward/inverse golden substitution tables.
package sbox_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 512;
    localparam int VEC_W       = 9;

    localparam logic [7:0] FWD_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/sbox_golden_rom.sv
// Combinational golden reference: returns the expected forward or inverse
// substitution for a byte. Kept separate so other S-box BISTs can reuse it.
module sbox_golden_rom
    import sbox_bist_pkg::*;
(
    input  logic [7:0] addr,
    input  logic       encrypt,
    output logic [7:0] expected
);

    // Select the forward or inverse table entry for the requested byte
    always_comb begin
        expected = encrypt ? FWD_SBOX[addr] : INV_SBOX[addr];
    end

endmodule

// File: rtl/sbox_bist.sv
// Self-test controller that sweeps an attached S-box through all 256 forward
// and 256 inverse vectors and reports the first mismatch.
// Optional macro SBOX_BIST_CONTINUE_EN: keep sweeping after a mismatch and
// count mismatches on err_count.
module sbox_bist
    import sbox_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [7:0]       sbox_byte_in,
    output logic             sbox_encrypt,
    input  logic [7:0]       sbox_byte_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [VEC_W-1:0] fail_index,
    output logic [7:0]       fail_got,
    output logic [7:0]       fail_exp
`ifdef SBOX_BIST_CONTINUE_EN
    ,
    output logic [9:0]       err_count
`endif
);

    localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    state_t           state;
    state_t           next_state;
    logic [VEC_W-1:0] vec;
    logic [3:0]       settle_cnt;
    logic [7:0]       golden;
    logic             mismatch;
    logic             last_vec;
    logic             stop_now;

    sbox_golden_rom u_rom (
        .addr     (vec[7:0]),
        .encrypt  (~vec[8]),
        .expected (golden)
    );

    // Case inequality so an undriven (X/Z) S-box output is flagged as a failure
    always_comb begin
        mismatch = (sbox_byte_out !== golden);
        last_vec = (vec == LAST_VEC);
`ifdef SBOX_BIST_CONTINUE_EN
        stop_now = 1'b0;
`else
        stop_now = mismatch;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus busy/done status derived from the current state
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD;
            end
            LOAD: begin
                busy       = 1'b1;
                next_state = DRIVE;
            end
            DRIVE: begin
                busy       = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (settle_cnt == 4'd0) next_state = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (last_vec || stop_now) next_state = DONE;
                else                      next_state = DRIVE;
            end
            DONE: begin
                done = 1'b1;
                if (start) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    // Sweep datapath: vector counter, S-box drive, settle timer and result capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec          <= '0;
            settle_cnt   <= '0;
            sbox_byte_in <= '0;
            sbox_encrypt <= 1'b1;
            pass         <= 1'b0;
            fail_index   <= '0;
            fail_got     <= '0;
            fail_exp     <= '0;
`ifdef SBOX_BIST_CONTINUE_EN
            err_count    <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    vec        <= '0;
                    pass       <= 1'b0;
                    fail_index <= '0;
                    fail_got   <= '0;
                    fail_exp   <= '0;
`ifdef SBOX_BIST_CONTINUE_EN
                    err_count  <= '0;
`endif
                end
                DRIVE: begin
                    sbox_byte_in <= vec[7:0];
                    sbox_encrypt <= ~vec[8];
                    settle_cnt   <= SETTLE_INIT;
                end
                WAIT: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
`ifdef SBOX_BIST_CONTINUE_EN
                    if (mismatch && err_count == 10'd0) begin
                        fail_index <= vec;
                        fail_got   <= sbox_byte_out;
                        fail_exp   <= golden;
                    end
                    if (mismatch && err_count != 10'd1023) err_count <= err_count + 10'd1;
                    if (last_vec) pass <= (err_count == 10'd0) && !mismatch;
`else
                    if (mismatch) begin
                        fail_index <= vec;
                        fail_got   <= sbox_byte_out;
                        fail_exp   <= golden;
                    end
                    if (last_vec) pass <= !mismatch;
`endif
                    if (!last_vec && !stop_now) vec <= vec + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
